m10k_write_sram0: RTL

- Write-side counterpart to the SRAM0 read path.
- Accepts a stream of 16-bit elements, packs 16 per 256-bit M10K word (lane 0 in bits [15:0]) and writes each full word to SRAM0 at consecutive addresses.
- Used to write result vectors back to SRAM0.
- Supports a flush that zero-pads and writes a partial word, then reports completion.

---
 rtl/m10k_write_sram0.sv | 85 ++++++++
 1 files changed

// File: rtl/m10k_write_sram0.sv
// m10k_write_sram0: packs 16-bit elements into 256-bit words and writes them to SRAM0 at consecutive addresses
module m10k_write_sram0 #(
  parameter int DATA_W = 16,
  parameter int LANES = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_write_start,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic                    i_elem_valid,
  input  logic [DATA_W-1:0]       i_elem_data,
  output logic                    o_elem_ready,
  input  logic                    i_flush,
  output logic                    o_write_en,
  output logic [ADDR_W-1:0]       o_write_addr,
  output logic [DATA_W*LANES-1:0] o_write_data,
  output logic [1:0]              o_state,
  output logic                    o_done,
  output logic [ADDR_W:0]         o_words_written,
  output logic                    o_wrap
);
  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {IDLE = 2'b00, PACK = 2'b01, WRITE = 2'b10, DONE = 2'b11} state_t;
  state_t state, state_n;
  logic [DATA_W*LANES-1:0] buffer;
  logic [LW-1:0] lane_cnt;
  logic [ADDR_W-1:0] addr;
  logic flush_pend, hs;
  assign hs = i_elem_valid && o_elem_ready;
  assign o_state = state;
  assign o_write_addr = addr;
  assign o_write_data = buffer;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    o_elem_ready = state == PACK;
    o_write_en = state == WRITE;
    o_done = state == DONE;
    case (state)
      IDLE: state_n = i_write_start ? PACK : IDLE;
      PACK: state_n = (hs && lane_cnt == LAST) || (i_flush && (hs || lane_cnt != '0)) ? WRITE : i_flush ? DONE : PACK;
      WRITE: state_n = flush_pend ? DONE : PACK;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      buffer <= '0;
      lane_cnt <= '0;
      addr <= '0;
      flush_pend <= 1'b0;
      o_words_written <= '0;
      o_wrap <= 1'b0;
    end else
      case (state)
        IDLE: if (i_write_start) begin
          addr <= i_base_addr;
          lane_cnt <= '0;
          buffer <= '0;
          o_words_written <= '0;
          o_wrap <= 1'b0;
          flush_pend <= 1'b0;
        end
        PACK: begin
          if (hs) begin
            buffer[lane_cnt*DATA_W +: DATA_W] <= i_elem_data;
            lane_cnt <= lane_cnt + 1'b1;
          end
          if (i_flush && (hs || lane_cnt != '0)) flush_pend <= 1'b1;
        end
        WRITE: begin
          addr <= addr + 1'b1;
          if (addr == '1) o_wrap <= 1'b1;
          if (o_words_written != CAP) o_words_written <= o_words_written + 1'b1;
          buffer <= '0;
          lane_cnt <= '0;
        end
        DONE: flush_pend <= 1'b0;
      endcase
endmodule
